cc3200_line_reader: RTL and testbench

CC3200_LINE_READER -- requirements
Module: cc3200_line_reader

---
 rtl/cc3200_line_reader.sv | 197 +++++++++++++++++++
 tb/tb_cc3200_line_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cc3200_line_reader.sv
// SPI slave that streams one frame of 2^ADDR_W pixel bytes from an image buffer, preceded by a header/command byte.
// Latency: SPI edges act 3 sysclk after the pin toggles (2-FF sync + edge detect); pixel prefetch lands 2 sysclk after the byte's first rise.
// Backpressure: none; the SPI master paces everything, and the buffer read is a fixed-latency prefetch with no stall path.
//
// Ports:
//   sysclk, RST                 sole clock, synchronous active-high reset
//   SPI_CLK, SPI_CS, SPI_DIN    asynchronous SPI master inputs (mode 0, CS active low)
//   SPI_DOUT                    slave data out, MSB first, advanced on synced SPI_CLK fall
//   Rd_Addr / Rd_Data           image-buffer read port, data valid 2 sysclk after address change
//   Cmd / Cmd_Valid             last complete command byte and its one-cycle update pulse
//   Busy / Frame_Done           transfer in progress; one-cycle pulse after the last pixel bit
module cc3200_line_reader #(
    parameter int          ADDR_W = 9,
    parameter logic [7:0]  HDR    = 8'hA5
) (
    input  logic              sysclk,
    input  logic              RST,
    input  logic              SPI_CLK,
    input  logic              SPI_CS,
    input  logic              SPI_DIN,
    output logic              SPI_DOUT,
    output logic [ADDR_W-1:0] Rd_Addr,
    input  logic [7:0]        Rd_Data,
    output logic [7:0]        Cmd,
    output logic              Cmd_Valid,
    output logic              Busy,
    output logic              Frame_Done
);

    typedef enum logic [1:0] {IDLE, CMD, PIX, DONE} state_t;

    state_t state, state_nxt;

    // synchronizers plus one delay stage each for edge detection
    logic cs_s1, cs_s2, cs_d;
    logic clk_s1, clk_s2, clk_d;
    logic din_s1, din_s2;

    // The CS chain resets high; if CS is held low through reset the chain
    // would fall right afterwards. A frame may only start once synced CS has
    // genuinely been seen high after the chain has flushed its reset value.
    logic [1:0] settle_cnt;
    logic       cs_armed;

    logic cs_rise, cs_fall, clk_rise, clk_fall;

    // datapath
    logic [6:0]        tx_sr;       // bits still to go out after SPI_DOUT
    logic [6:0]        rx_sr;       // first seven received bits of a byte
    logic [7:0]        hold;        // prefetched next byte
    logic [2:0]        bit_cnt;
    logic [ADDR_W-1:0] pix_cnt;     // pixel currently being shifted
    logic [1:0]        fetch_p;     // delay line from first rise to Rd_Data capture

    // FSM strobes
    logic start, do_rise, do_fall, cmd_done, frame_end;

    always_ff @(posedge sysclk) begin
        if (RST) begin
            cs_s1      <= 1'b1;
            cs_s2      <= 1'b1;
            cs_d       <= 1'b1;
            clk_s1     <= 1'b0;
            clk_s2     <= 1'b0;
            clk_d      <= 1'b0;
            din_s1     <= 1'b0;
            din_s2     <= 1'b0;
            settle_cnt <= 2'd0;
            cs_armed   <= 1'b0;
        end else begin
            cs_s1      <= SPI_CS;
            cs_s2      <= cs_s1;
            cs_d       <= cs_s2;
            clk_s1     <= SPI_CLK;
            clk_s2     <= clk_s1;
            clk_d      <= clk_s2;
            din_s1     <= SPI_DIN;
            din_s2     <= din_s1;
            settle_cnt <= (settle_cnt == 2'd2) ? 2'd2 : settle_cnt + 2'd1;
            cs_armed   <= cs_armed | ((settle_cnt == 2'd2) & cs_s2);
        end
    end

    assign cs_rise  =  cs_s2 & ~cs_d;
    assign cs_fall  = ~cs_s2 &  cs_d & cs_armed;
    assign clk_rise =  clk_s2 & ~clk_d;
    assign clk_fall = ~clk_s2 &  clk_d;

    always_ff @(posedge sysclk) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // CS rise overrides everything, including a clock edge in the same cycle.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        do_rise   = 1'b0;
        do_fall   = 1'b0;
        cmd_done  = 1'b0;
        frame_end = 1'b0;
        if (cs_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_nxt = CMD;
                        start     = 1'b1;
                    end
                end
                CMD: begin
                    do_rise = clk_rise;
                    do_fall = clk_fall;
                    if (clk_rise && bit_cnt == 3'd7) begin
                        cmd_done  = 1'b1;
                        state_nxt = PIX;
                    end
                end
                PIX: begin
                    do_rise = clk_rise;
                    do_fall = clk_fall;
                    if (clk_rise && bit_cnt == 3'd7 && pix_cnt == '1) begin
                        frame_end = 1'b1;
                        state_nxt = DONE;
                    end
                end
                default: ;  // DONE: wait for CS rise, ignore the clock
            endcase
        end
    end

    assign Busy = (state != IDLE);

    always_ff @(posedge sysclk) begin
        if (RST) begin
            SPI_DOUT   <= 1'b0;
            Rd_Addr    <= '0;
            Cmd        <= 8'h00;
            Cmd_Valid  <= 1'b0;
            Frame_Done <= 1'b0;
            tx_sr      <= 7'd0;
            rx_sr      <= 7'd0;
            hold       <= 8'h00;
            bit_cnt    <= 3'd0;
            pix_cnt    <= '0;
            fetch_p    <= 2'b00;
        end else begin
            Cmd_Valid  <= cmd_done;
            Frame_Done <= frame_end;
            if (cs_rise) begin
                SPI_DOUT <= 1'b0;
                fetch_p  <= 2'b00;
            end else if (start) begin
                tx_sr    <= HDR[6:0];
                SPI_DOUT <= HDR[7];
                bit_cnt  <= 3'd0;
                pix_cnt  <= '0;
                Rd_Addr  <= '0;
                fetch_p  <= 2'b00;
            end else begin
                // Rd_Addr always points at the pixel of the next byte; it is
                // captured two cycles after the current byte's first rise and
                // then advanced, saturating on the last pixel.
                fetch_p <= {fetch_p[0], do_rise && (bit_cnt == 3'd0)};
                if (fetch_p[1]) begin
                    hold <= Rd_Data;
                    if (Rd_Addr != '1)
                        Rd_Addr <= Rd_Addr + ADDR_W'(1);
                end

                if (do_rise) begin
                    rx_sr   <= {rx_sr[5:0], din_s2};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (cmd_done)
                    Cmd <= {rx_sr, din_s2};
                if (do_rise && bit_cnt == 3'd7 && state == PIX)
                    pix_cnt <= pix_cnt + ADDR_W'(1);

                if (frame_end) begin
                    SPI_DOUT <= 1'b0;
                end else if (do_fall) begin
                    if (bit_cnt != 3'd0) begin
                        SPI_DOUT <= tx_sr[6];
                        tx_sr    <= {tx_sr[5:0], 1'b0};
                    end else if (state == PIX) begin
                        // fall after the 8th rise: start the prefetched byte
                        SPI_DOUT <= hold[7];
                        tx_sr    <= hold[6:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cc3200_line_reader.sv
// Self-checking bench for cc3200_line_reader: random SPI traffic against a frame-level byte model.
// Latency: SPI master runs at sysclk/8 or slower; image buffer model has 2-cycle read latency.
// Backpressure: none; the bench master paces all transfers.
module tb_cc3200_line_reader;

    localparam int         AW   = 9;
    localparam int         NPIX = 1 << AW;
    localparam logic [7:0] HDR  = 8'hA5;

    logic          sysclk = 1'b0;
    logic          RST = 1'b1;
    logic          SPI_CLK = 1'b0;
    logic          SPI_CS = 1'b1;
    logic          SPI_DIN = 1'b0;
    logic          SPI_DOUT;
    logic [AW-1:0] Rd_Addr;
    logic [7:0]    Rd_Data = 8'h00;
    logic [7:0]    Cmd;
    logic          Cmd_Valid;
    logic          Busy;
    logic          Frame_Done;

    cc3200_line_reader #(.ADDR_W(AW), .HDR(HDR)) dut (
        .sysclk     (sysclk),
        .RST        (RST),
        .SPI_CLK    (SPI_CLK),
        .SPI_CS     (SPI_CS),
        .SPI_DIN    (SPI_DIN),
        .SPI_DOUT   (SPI_DOUT),
        .Rd_Addr    (Rd_Addr),
        .Rd_Data    (Rd_Data),
        .Cmd        (Cmd),
        .Cmd_Valid  (Cmd_Valid),
        .Busy       (Busy),
        .Frame_Done (Frame_Done)
    );

    always #5 sysclk = ~sysclk;

    // image buffer with 2-cycle read latency
    logic [7:0] mem [0:NPIX-1];
    logic [7:0] rd_d1 = 8'h00;
    always @(posedge sysclk) begin
        rd_d1   <= mem[Rd_Addr];
        Rd_Data <= rd_d1;
    end

    int checks = 0;
    int failures = 0;
    int cv_cnt = 0;
    int fd_cnt = 0;

    always @(negedge sysclk) begin
        if (Cmd_Valid)  cv_cnt++;
        if (Frame_Done) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    // Byte k of a frame: header, then pixels in address order, then silence.
    function automatic logic [7:0] exp_byte(input int k);
        if (k == 0)         return HDR;
        else if (k <= NPIX) return mem[k-1];
        else                return 8'h00;
    endfunction

    // Mode-0 master: DIN changes with the falling edge, DOUT sampled at the rise.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, input int half,
                            output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            SPI_DIN = mo[7-i];
            tick(half);
            mi = {mi[6:0], SPI_DOUT};
            SPI_CLK = 1'b1;
            tick(half);
            SPI_CLK = 1'b0;
        end
    endtask

    task automatic frame_bytes(input logic [7:0] cmd, input int first, input int nbytes,
                               input int half);
        logic [7:0] mo, mi;
        for (int k = first; k < first + nbytes; k++) begin
            mo = (k == 0) ? cmd : 8'($urandom);
            spi_xfer(mo, 8, half, mi);
            check($sformatf("miso_byte%0d", k), 32'(mi), 32'(exp_byte(k)));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dout"},  32'(SPI_DOUT),   32'd0);
        check({tag, "_addr"},  32'(Rd_Addr),    32'd0);
        check({tag, "_cmd"},   32'(Cmd),        32'd0);
        check({tag, "_cv"},    32'(Cmd_Valid),  32'd0);
        check({tag, "_busy"},  32'(Busy),       32'd0);
        check({tag, "_fd"},    32'(Frame_Done), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int         c0, f0, n, half;
        logic [7:0] cmd_b, cmd_c, mi;

        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);

        // reset state
        RST = 1'b1;
        tick(4);
        check_outputs_zero("reset");
        RST = 1'b0;
        tick(4);

        // full frame, command 3C, ramp image
        c0 = cv_cnt;
        f0 = fd_cnt;
        SPI_CS = 1'b0;
        frame_bytes(8'h3C, 0, NPIX + 1, 4);
        check("frameA_cmd", 32'(Cmd), 32'h3C);
        check("frameA_cv_pulses", 32'(cv_cnt - c0), 32'd1);
        check("frameA_fd_pulses", 32'(fd_cnt - f0), 32'd1);

        // 16 extra clocks in DONE: silence, address parked, no second pulse
        frame_bytes(8'h00, NPIX + 1, 2, 4);
        check("done_addr", 32'(Rd_Addr), 32'(NPIX - 1));
        check("done_fd_pulses", 32'(fd_cnt - f0), 32'd1);
        check("done_busy", 32'(Busy), 32'd1);

        // back-to-back: CS high for just 2 cycles, new random image
        tick(4);
        SPI_CS = 1'b1;
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
        tick(2);
        SPI_CS = 1'b0;
        cmd_b = 8'($urandom);
        frame_bytes(cmd_b, 0, NPIX + 1, 4);
        check("frameB_cmd", 32'(Cmd), 32'(cmd_b));
        check("b2b_cv_pulses", 32'(cv_cnt - c0), 32'd2);
        check("b2b_fd_pulses", 32'(fd_cnt - f0), 32'd2);
        tick(4);
        SPI_CS = 1'b1;
        n = 0;
        while (Busy && n < 10) begin
            tick(1);
            n++;
        end
        check("busy_low_3to4", 32'(n >= 3 && n <= 4), 32'd1);
        tick(4);

        // abort after 4 command bits
        c0 = cv_cnt;
        SPI_CS = 1'b0;
        spi_xfer(8'($urandom), 4, 4, mi);
        check("abort_cmd_hdr_nibble", 32'(mi[3:0]), 32'(HDR[7:4]));
        tick(2);
        SPI_CS = 1'b1;
        tick(6);
        check("abort_cmd_cv", 32'(cv_cnt - c0), 32'd0);
        check("abort_cmd_keep", 32'(Cmd), 32'(cmd_b));
        check("abort_cmd_dout", 32'(SPI_DOUT), 32'd0);
        check("abort_cmd_busy", 32'(Busy), 32'd0);

        // abort in the middle of pixel 100, then restart with inverted image
        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
        c0 = cv_cnt;
        f0 = fd_cnt;
        half = $urandom_range(6, 4);
        SPI_CS = 1'b0;
        frame_bytes(8'($urandom), 0, 101, half);
        spi_xfer(8'($urandom), 4, half, mi);
        tick(half);
        SPI_CS = 1'b1;
        for (int i = 0; i < NPIX; i++) mem[i] = ~8'(i);
        tick(6);
        check("abort_pix_busy", 32'(Busy), 32'd0);
        check("abort_pix_dout", 32'(SPI_DOUT), 32'd0);
        half = $urandom_range(6, 4);
        SPI_CS = 1'b0;
        frame_bytes(8'($urandom), 0, 9, half);
        tick(half);
        SPI_CS = 1'b1;
        tick(6);
        check("abort_pix_fd", 32'(fd_cnt - f0), 32'd0);
        check("abort_pix_cv", 32'(cv_cnt - c0), 32'd2);

        // reset at pixel 50 with CS held low
        SPI_CS = 1'b0;
        frame_bytes(8'($urandom), 0, 51, 4);
        spi_xfer(8'($urandom), 3, 4, mi);
        RST = 1'b1;
        tick(2);
        check_outputs_zero("midrst");
        RST = 1'b0;
        tick(4);
        c0 = cv_cnt;
        for (int b = 0; b < 2; b++) begin
            spi_xfer(8'($urandom), 8, 4, mi);
            check("midrst_ignored_dout", 32'(mi), 32'd0);
            check("midrst_ignored_busy", 32'(Busy), 32'd0);
        end
        check("midrst_ignored_addr", 32'(Rd_Addr), 32'd0);
        check("midrst_ignored_cv", 32'(cv_cnt - c0), 32'd0);
        SPI_CS = 1'b1;
        tick(4);
        SPI_CS = 1'b0;
        cmd_c = 8'($urandom);
        frame_bytes(cmd_c, 0, 5, 5);
        check("midrst_restart_cmd", 32'(Cmd), 32'(cmd_c));
        tick(5);
        SPI_CS = 1'b1;
        tick(6);
        check("final_busy", 32'(Busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
